mult_div_unit: RTL

- Multi-cycle signed multiply/divide responder for the MIPS datapath. It serves the mult and div instructions.
- The control unit acts as initiator: it pulses start with an operation select, waits for done, then reads hi/lo into the HI/LO path.
- Operands come from the Regs_AB register outputs. The block owns the HI and LO registers.

---
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle signed multiply/divide unit for the MIPS datapath. The
//   control unit pulses start with op, waits for done, then reads hi/lo.
//   Multiply is unsigned shift-add on magnitudes, and divide is unsigned
//   restoring division on magnitudes. Both take WIDTH iterations and
//   finish with one sign-correction/commit cycle.
//
// Ports
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   start    operation request, sampled only when idle
//   op       0 = signed mult, 1 = signed div
//   a, b     operands (multiplicand/dividend, multiplier/divisor)
//   busy     operation in progress
//   done     one-cycle pulse when the result is committed or div-by-zero
//   div_zero one-cycle pulse with done when a div had b == 0
//   hi, lo   HI/LO registers (mult: product halves; div: remainder/quotient)

module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DZ   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             op_q;
    logic             neg_q;    // product / quotient sign
    logic             neg_r;    // remainder sign (dividend sign)
    logic [WIDTH-1:0] opb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc;      // partial product high half / partial remainder
    logic [WIDTH-1:0] mq;       // multiplier shifting out / dividend-quotient

    // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1).
    logic [WIDTH-1:0] abs_a, abs_b;
    assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Multiply step: add the multiplicand if the current multiplier bit is
    // set, then shift {carry, acc, mq} right by one.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);

    // Restoring divide step: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits. The shifted remainder needs one
    // extra bit. The difference is below 2^WIDTH, so the low bits are exact.
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    assign div_sh   = {acc, mq[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, opb});
    assign div_diff = div_sh[WIDTH-1:0] - opb;

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;
    assign prod_s = neg_q ? -{acc, mq} : {acc, mq};
    assign quot_s = neg_q ? -mq  : mq;
    assign rem_s  = neg_r ? -acc : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            opb      <= '0;
            acc      <= '0;
            mq       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        op_q <= op;
                        if (op && (b == '0)) begin
                            state <= S_DZ;
                        end else begin
                            state <= S_RUN;
                            cnt   <= CNT_W'(WIDTH - 1);
                            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r <= a[WIDTH-1];
                            acc   <= '0;
                            opb   <= op ? abs_b : abs_a;
                            mq    <= op ? abs_a : abs_b;
                        end
                    end
                end
                S_RUN: begin
                    if (op_q) begin
                        acc <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                        mq  <= {mq[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    end
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (op_q) begin
                        hi <= rem_s;
                        lo <= quot_s;
                    end else begin
                        hi <= prod_s[2*WIDTH-1:WIDTH];
                        lo <= prod_s[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_DZ: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
